// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PIC types and default timing constants
// Purpose: state encoding for the INTA sequencer, vector width, and the
//          default acknowledge timing shared by the PIC, sequencer and benches.
// Ports:   none (package)
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE1,
    GAP,
    PULSE2,
    HOLD
  } inta_state_t;

  localparam int VECTOR_W = 8;

  localparam int DEF_PULSE_CYCLES = 4;
  localparam int DEF_GAP_CYCLES   = 2;
  localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/pic_sync_bit.sv
// rtl/pic_sync_bit.sv - multi-stage synchronizer for one asynchronous bit
// Purpose: brings an asynchronous PIC-side level into the clk domain.
// Ports:   clk   - system clock
//          reset - asynchronous active-high reset, clears the chain
//          d     - asynchronous input
//          q     - synchronized output (last stage, SYNC_STAGES edges late)
module pic_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - 8086-style two-pulse interrupt acknowledge engine
// Purpose: turns the PIC INT level into an INTA pulse pair, captures the
//          vector driven during pulse 2 and offers it to the core.
// Ports:   clk, reset            - clock, asynchronous active-high reset
//          INT                   - asynchronous interrupt request from the PIC
//          int_enable            - CPU IF flag, gates new sequences only
//          INTA, lock_n          - registered active-low acknowledge / bus lock
//          data_bus_in           - PIC data bus, sampled leaving pulse 2
//          vector_out/valid/ready - vector handshake toward the core
//          busy                  - sequencer not idle
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                INT,
  input  logic                int_enable,
  output logic                INTA,
  output logic                lock_n,
  input  logic [VECTOR_W-1:0] data_bus_in,
  output logic [VECTOR_W-1:0] vector_out,
  output logic                vector_valid,
  input  logic                vector_ready,
  output logic                busy
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic int_s;

  pic_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk  (clk),
    .reset(reset),
    .d    (INT),
    .q    (int_s)
  );

  inta_state_t         state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                inta_nx, lock_nx, valid_nx;
  logic [VECTOR_W-1:0] vec_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      INTA         <= 1'b1;
      lock_n       <= 1'b1;
      vector_out   <= '0;
      vector_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      INTA         <= inta_nx;
      lock_n       <= lock_nx;
      vector_out   <= vec_nx;
      vector_valid <= valid_nx;
    end
  end

  // Each timed state lasts (load + 1) cycles: the edge that sees cnt == 0
  // is the one that moves on, so outputs change on the same edge as state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    inta_nx  = INTA;
    lock_nx  = lock_n;
    vec_nx   = vector_out;
    valid_nx = vector_valid;
    case (state)
      IDLE: begin
        if (int_s && int_enable && !vector_valid) begin
          state_nx = PULSE1;
          cnt_nx   = PULSE_LOAD;
          inta_nx  = 1'b0;
          lock_nx  = 1'b0;
        end
      end
      PULSE1: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
          inta_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx = PULSE2;
          cnt_nx   = PULSE_LOAD;
          inta_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      PULSE2: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          vec_nx   = data_bus_in;
          inta_nx  = 1'b1;
          lock_nx  = 1'b1;
          valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (vector_valid && vector_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - self-checking bench for pic_inta_sequencer
module tb_pic_inta_sequencer;

  localparam int P = 4;
  localparam int G = 2;
  localparam int S = 2;
  localparam int SEQ_LEN = 2 * P + G;

  logic       clk = 1'b0;
  logic       reset;
  logic       INT;
  logic       int_enable;
  logic       INTA;
  logic       lock_n;
  logic [7:0] data_bus_in;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       vector_ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  pic_inta_sequencer #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .INT         (INT),
    .int_enable  (int_enable),
    .INTA        (INTA),
    .lock_n      (lock_n),
    .data_bus_in (data_bus_in),
    .vector_out  (vector_out),
    .vector_valid(vector_valid),
    .vector_ready(vector_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a timeline of SEQ_LEN cycles measured from
  // the start edge; outputs follow from the offset k into that timeline.
  bit [S-1:0] hist;
  bit         m_seq;
  bit         m_hold;
  int         k;
  logic [7:0] m_vec;

  always @(posedge clk) begin
    if (reset) begin
      hist   = '0;
      m_seq  = 1'b0;
      m_hold = 1'b0;
      k      = 0;
      m_vec  = 8'h00;
    end else begin
      bit ints;
      ints = hist[S-1];
      if (m_seq) begin
        k++;
        if (k == SEQ_LEN) begin
          m_seq  = 1'b0;
          m_hold = 1'b1;
          m_vec  = data_bus_in;
        end
      end else if (m_hold) begin
        if (vector_ready) m_hold = 1'b0;
      end else if (ints && int_enable) begin
        m_seq = 1'b1;
        k     = 0;
      end
      hist = {hist[S-2:0], INT};
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_inta",  INTA,         !(m_seq && (k < P || k >= P + G)));
    chk("m_lock",  lock_n,       !m_seq);
    chk("m_valid", vector_valid, m_hold);
    chk("m_busy",  busy,         m_seq || m_hold);
    chk("m_vec",   vector_out,   m_vec);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event at %0t", name, $time);
  endtask

  // Runs one acknowledge from its first INTA-low sample to vector_valid,
  // measuring the timeline; drop_at >= 0 releases INT at that offset.
  task automatic run_ack(input logic [7:0] vec, input int drop_at);
    int n, t, il, ll;
    data_bus_in = vec;
    n = 0;
    while (INTA !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      timeout("ack_start");
      return;
    end
    t = 0; il = 0; ll = 0;
    while (vector_valid !== 1'b1 && t < 50) begin
      if (t == drop_at) INT = 1'b0;
      if (INTA === 1'b0) il++;
      if (lock_n === 1'b0) ll++;
      tick();
      t++;
    end
    chk("ack_latency",   t,          10);
    chk("ack_inta_low",  il,         8);
    chk("ack_lock_low",  ll,         10);
    chk("ack_vector",    vector_out, vec);
  endtask

  initial begin
    int lows, bad;
    reset = 1'b1; INT = 1'b0; int_enable = 1'b0; vector_ready = 1'b0; data_bus_in = 8'h00;

    // reset then idle
    repeat (3) tick();
    chk("rst_inta",  INTA,         1);
    chk("rst_lock",  lock_n,       1);
    chk("rst_valid", vector_valid, 0);
    chk("rst_busy",  busy,         0);
    chk("rst_vec",   vector_out,   8'h00);
    #2 reset = 1'b0;
    lows = 0;
    repeat (20) begin tick(); if (INTA === 1'b0 || lock_n === 1'b0 || busy) lows++; end
    chk("idle_quiet", lows, 0);

    // single acknowledge
    int_enable = 1'b1; vector_ready = 1'b1; INT = 1'b1;
    run_ack(8'h48, 5);
    tick();
    chk("valid_one_cycle", vector_valid, 0);
    repeat (10) tick();

    // masked, then unmask
    int_enable = 1'b0; INT = 1'b1;
    lows = 0;
    repeat (30) begin tick(); if (INTA === 1'b0 || busy) lows++; end
    chk("masked_quiet", lows, 0);
    int_enable = 1'b1;
    tick();
    chk("unmask_start", INTA, 0);
    run_ack(8'h21, 5);
    repeat (10) tick();

    // backpressure with INT held high
    vector_ready = 1'b0; INT = 1'b1;
    run_ack(8'h0F, -1);
    bad = 0;
    repeat (50) begin
      tick();
      if (vector_valid !== 1'b1 || vector_out !== 8'h0F || INTA !== 1'b1 || lock_n !== 1'b1) bad++;
    end
    chk("hold_stable", bad, 0);
    vector_ready = 1'b1;
    tick();
    chk("consume_valid", vector_valid, 0);
    chk("consume_inta",  INTA,         1);
    tick();
    chk("b2b_start", INTA, 0);
    INT = 1'b0;
    repeat (20) tick();

    // reset during GAP
    data_bus_in = 8'h33; INT = 1'b1;
    lows = 0;
    while (INTA !== 1'b0 && lows < 100) begin tick(); lows++; end
    if (lows >= 100) timeout("gap_start");
    repeat (P) tick();
    chk("in_gap_inta", INTA,   1);
    chk("in_gap_lock", lock_n, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_lock",  lock_n,       1);
    chk("async_inta",  INTA,         1);
    chk("async_busy",  busy,         0);
    chk("async_valid", vector_valid, 0);
    tick(); tick();
    #2 reset = 1'b0;
    run_ack(8'h33, 5);
    repeat (10) tick();

    // INT drops in PULSE1, PIC answers IR7
    INT = 1'b1;
    run_ack(8'h57, 0);
    repeat (10) tick();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) INT = ~INT;
      int_enable   = ($urandom_range(0, 7) != 0);
      vector_ready = $urandom_range(0, 1);
      data_bus_in  = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        tick();
        #2 reset = 1'b0;
      end
      tick();
    end

    reset = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- CPU-side interrupt acknowledge engine sitting directly downstream of the 8259 PIC.
- Consumes the PIC's INT output and generates the 8086-style two-pulse INTA cycle back to the PIC.
- Captures the 8-bit vector the PIC drives on the data bus during the second pulse and hands it to the CPU core over a valid/ready handshake.
- Replaces the bench-only acknowledge task with synthesizable RTL.

Parameters:
- PULSE_CYCLES, 4: clk cycles each INTA low pulse lasts (>=2).
- GAP_CYCLES, 2: clk cycles INTA is high between pulse 1 and pulse 2 (>=1).
- SYNC_STAGES, 2: flip-flop stages synchronizing INT (>=2).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- INT  input  1  interrupt request from PIC, asynchronous to clk.
- int_enable  input  1  CPU interrupt flag (IF); new sequences start only when 1.
- INTA  output  1  acknowledge to PIC, active low, registered.
- lock_n  output  1  bus lock, active low, asserted for the whole sequence, registered.
- data_bus_in  input  8  PIC data bus (vector appears during pulse 2).
- vector_out  output  8  captured vector.
- vector_valid  output  1  vector_out holds an unconsumed vector.
- vector_ready  input  1  core accepts vector when valid&&ready at a clk edge.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: INTA=1, lock_n=1, vector_out=8'h00, vector_valid=0, busy=0, FSM=IDLE, counter=0, sync chain=0.
- Reset is honoured mid-sequence: the asynchronous assert forces all reset values immediately, truncating any INTA pulse. No vector is produced for the aborted sequence.
- INT passes through SYNC_STAGES flops. int_s is the last stage, so latency is SYNC_STAGES edges.
- Down-counter width is $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1).
- States: IDLE, PULSE1, GAP, PULSE2, HOLD.
- IDLE: if int_s && int_enable && !vector_valid, go to PULSE1, load counter=PULSE_CYCLES-1, and set INTA=0, lock_n=0 on the same edge.
- PULSE1: hold INTA=0 for exactly PULSE_CYCLES cycles. When the counter reaches 0, go to GAP, set INTA=1, load GAP_CYCLES-1.
- GAP: hold INTA=1, lock_n=0 for exactly GAP_CYCLES cycles, then go to PULSE2, set INTA=0, load PULSE_CYCLES-1.
- PULSE2: hold INTA=0 for PULSE_CYCLES cycles. On the edge leaving PULSE2 (counter==0):
  - vector_out <= data_bus_in;
  - INTA <= 1, lock_n <= 1;
  - vector_valid <= 1;
  - go to HOLD.
- HOLD: vector_out is stable while valid. On valid&&ready, clear vector_valid and go to IDLE. A new sequence can start no earlier than the edge after IDLE is re-entered.
- Once PULSE1 begins, the sequence always completes even if INT or int_enable drops. Dropping INT mid-sequence is a PIC spurious-interrupt case; the PIC supplies IR7, and the sequencer does not special-case it.
- int_enable low while in IDLE with INT high: remain in IDLE, all outputs quiescent.
- vector_ready asserted while vector_valid=0: ignored.
- INT still high after HOLD→IDLE: a new sequence starts on the next eligible edge. Back-to-back acknowledges are legal.
- Sequence length from the first INTA low to vector_valid=1 is 2*PULSE_CYCLES+GAP_CYCLES cycles (10 with defaults).

Decomposition:
- Shared package pic_pkg holds:
  - state enum inta_state_t {IDLE, PULSE1, GAP, PULSE2, HOLD};
  - localparam VECTOR_W=8;
  - default timing constants, shared with the PIC and benches.
- One natural sub-module: pic_sync_bit (parameterized SYNC_STAGES flop chain, async reset to 0), reused for other asynchronous PIC-side inputs.
- FSM, counter and capture register stay in pic_inta_sequencer.

Test Plan:
- Reset then idle: hold reset 3 cycles, INT=0 → INTA=1, lock_n=1, vector_valid=0, busy=0 for 20 cycles.
- Single acknowledge: int_enable=1, INT=1, PIC drives data_bus_in=8'h48 during pulse 2, vector_ready=1 → INTA low 4 cycles, high 2, low 4; lock_n low all 10 cycles; vector_out=8'h48 with valid for 1 cycle.
- Masked: int_enable=0, INT=1 for 30 cycles → INTA never toggles. Raise int_enable → first INTA low exactly SYNC_STAGES-independent 1 edge later (int_s already high).
- Backpressure: vector_ready=0, vector 8'h0F captured, INT held high → valid stays 1, vector_out=8'h0F stable, no new INTA for 50 cycles. Assert ready → second sequence begins the edge after IDLE.
- Reset mid-sequence: assert reset during GAP → INTA=1, lock_n=1 immediately (before next edge), vector_valid=0. After release with INT=1, a full fresh sequence runs.
- INT drops during PULSE1: PIC returns 8'h57 (IR7) → sequence completes full 10 cycles and delivers vector_out=8'h57.
